// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int unsigned MULT_WIDTH = 8;
    localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH + 1);

endpackage

// File: rtl/mult_secuencial_sumador_n.sv
// Parameterized ripple-carry adder built from full-adder cells; carry-out of the top cell is dropped.
module sumador_n #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] s
);

    logic [N-1:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < N - 1) begin : g_carry
            assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/mult_secuencial.sv
// Sequential unsigned multiplier, one partial product per clock, START/DONE handshake.
// Optional MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module mult_secuencial
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [2*WIDTH-1:0] P,
    output logic               BUSY,
    output logic               DONE
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t          state;
    logic [PW-1:0]   mc;
    logic [WIDTH-1:0] mq;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   cnt;

    logic [PW-1:0]    sum_c;
    logic [PW-1:0]    acc_nxt_c;
    logic [WIDTH-1:0] mq_nxt_c;
    logic [CW-1:0]    cnt_nxt_c;
    logic             last_c;

    sumador_n #(.N(PW)) u_sumador (
        .a (acc),
        .b (mc),
        .s (sum_c)
    );

    // Next datapath values for a RUN step
    always_comb begin
        acc_nxt_c = mq[0] ? sum_c : acc;
        mq_nxt_c  = mq >> 1;
        cnt_nxt_c = cnt - CW'(1);
`ifdef MULT_EARLY_EXIT_EN
        last_c    = (cnt_nxt_c == '0) || (mq_nxt_c == '0);
`else
        last_c    = (cnt_nxt_c == '0);
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            mc    <= '0;
            mq    <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        mc  <= {WIDTH'(0), A};
                        mq  <= B;
                        acc <= '0;
                        cnt <= CW'(WIDTH);
`ifdef MULT_EARLY_EXIT_EN
                        // Zero multiplier needs no iterations
                        if (B == '0) begin
                            state <= FIN;
                            P     <= '0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end
`else
                        state <= RUN;
                        BUSY  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    acc <= acc_nxt_c;
                    mc  <= mc << 1;
                    mq  <= mq_nxt_c;
                    cnt <= cnt_nxt_c;
                    if (last_c) begin
                        P     <= acc_nxt_c;
                        state <= FIN;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_secuencial.sv
// Scoreboard bench for mult_secuencial; latency expectations follow MULT_EARLY_EXIT_EN.
module tb_mult_secuencial;

    localparam int unsigned W = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic           START;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] P;
    logic           BUSY;
    logic           DONE;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    logic [2*W-1:0] sb[$];

    mult_secuencial #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .P     (P),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] b);
        int m;
`ifdef MULT_EARLY_EXIT_EN
        m = 0;
        for (int i = 0; i < int'(W); i++)
            if (b[i]) m = i + 1;
`else
        m = int'(W);
`endif
        return m;
    endfunction

    // Product check whenever DONE is seen
    always @(negedge CLK) begin
        if (DONE) begin
            done_cnt++;
            if (sb.size() == 0)
                check("spurious_done", 32'(1), 32'(0));
            else
                check("P", 32'(P), 32'(sb.pop_front()));
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int lat, busy_n, el, d0;
        bit seen;
        logic [2*W-1:0] exp_p;
        exp_p = (2*W)'(a) * (2*W)'(b);
        el = exp_latency(b);
        d0 = done_cnt;
        @(negedge CLK);
        A = a; B = b; START = 1'b1;
        @(posedge CLK);
        sb.push_back(exp_p);
        lat = 0; busy_n = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                START = 1'b0;
            end else begin
                if (BUSY) busy_n++;
                lat++;
                if (hold) begin
                    START = 1'b1;
                    A = W'($urandom);
                    B = W'($urandom);
                end else begin
                    START = 1'b0;
                end
            end
        end
        check("latency", 32'(lat), 32'(el));
        check("busy_cycles", 32'(busy_n), 32'(el));
        @(negedge CLK);
        check("P_hold", 32'(P), 32'(exp_p));
        check("busy_after", 32'(BUSY), 32'(0));
        check("done_count", 32'(done_cnt - d0), 32'(1));
    endtask

    initial begin
        RST = 1'b1; START = 1'b1; A = 8'd5; B = 8'd5;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_P", 32'(P), 32'(0));
        check("rst_BUSY", 32'(BUSY), 32'(0));
        check("rst_DONE", 32'(DONE), 32'(0));
        RST = 1'b0; START = 1'b0;
        @(negedge CLK);
        check("idle_BUSY", 32'(BUSY), 32'(0));

        run_op(8'd13, 8'd11, 1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'd0, 8'd200, 1'b0);
        run_op(8'd57, 8'd3, 1'b1);

        // Abort: reset sampled on edge k+4
        @(negedge CLK);
        A = 8'd100; B = 8'd99; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort_P", 32'(P), 32'(0));
        check("abort_BUSY", 32'(BUSY), 32'(0));
        check("abort_DONE", 32'(DONE), 32'(0));
        RST = 1'b0;
        repeat (12) @(negedge CLK);
        check("abort_no_done", 32'(DONE), 32'(0));
        run_op(8'd7, 8'd6, 1'b0);

        run_op(8'd3, 8'd5, 1'b0);
        run_op(8'd9, 8'd0, 1'b0);
        run_op(8'd2, 8'd128, 1'b0);
        run_op(8'd200, 8'd1, 1'b0);
        for (int n = 0; n < 6; n++)
            run_op(W'($urandom), W'($urandom), n[0]);

        repeat (3) @(negedge CLK);
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
